vga_plot_arbiter: RTL and testbench

Single owner of the VGA adapter's pixel-write port (x, y, colour, plot). Two game-side requesters, food spawner (port A) and snake body/erase engine (port B), share the port through valid/ready handshakes with round-robin arbitration. An internal clear sequencer sweeps the full 160x120 frame to a background colour on game reset or death. Sits between the game datapath and `vga_adapter`, replacing ad-hoc muxing of coordinate sources.

---
 rtl/vga_plot_arbiter_pkg.sv | 20 ++
 rtl/vga_plot_arbiter_screen_sweep.sv | 57 +++++
 rtl/vga_plot_arbiter.sv | 136 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared frame geometry, palette constants and arbiter state type for the VGA
// pixel-write path.
package vga_plot_arbiter_pkg;

    localparam int unsigned VGA_H_RES = 160;
    localparam int unsigned VGA_V_RES = 120;
    localparam int unsigned VGA_X_W   = 8;
    localparam int unsigned VGA_Y_W   = 7;
    localparam int unsigned VGA_COL_W = 3;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic {
        StIdle,
        StClear
    } arb_state_e;

endpackage

// File: rtl/vga_plot_arbiter_screen_sweep.sv
// Row-major raster counter: x runs fastest, both wrap to zero after the last
// pixel of the frame.
module vga_plot_arbiter_screen_sweep
    import vga_plot_arbiter_pkg::*;
#(
    parameter int unsigned H_RES = VGA_H_RES,
    parameter int unsigned V_RES = VGA_V_RES,
    parameter int unsigned X_W   = VGA_X_W,
    parameter int unsigned Y_W   = VGA_Y_W
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start_i,
    input  logic           en_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_last, y_last;

    assign x_last = (32'(x_q) == H_RES - 1);
    assign y_last = (32'(y_q) == V_RES - 1);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = x_last && y_last;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Sole owner of the VGA adapter write port: round-robin between the food and
// snake requesters, plus a full-frame background clear sweep.
module vga_plot_arbiter
    import vga_plot_arbiter_pkg::*;
#(
    parameter int unsigned          H_RES      = VGA_H_RES,
    parameter int unsigned          V_RES      = VGA_V_RES,
    parameter int unsigned          X_W        = VGA_X_W,
    parameter int unsigned          Y_W        = VGA_Y_W,
    parameter int unsigned          COL_W      = VGA_COL_W,
    parameter logic [COL_W-1:0]     BG_COLOUR  = COL_W'(COL_BLACK),
    parameter bit                   AUTO_CLEAR = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_req_i,
    output logic             clear_busy_o,
    output logic             clear_done_o,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [X_W-1:0]   a_x_i,
    input  logic [Y_W-1:0]   a_y_i,
    input  logic [COL_W-1:0] a_col_i,
    input  logic             b_valid_i,
    output logic             b_ready_o,
    input  logic [X_W-1:0]   b_x_i,
    input  logic [Y_W-1:0]   b_y_i,
    input  logic [COL_W-1:0] b_col_i,
    output logic [X_W-1:0]   vga_x_o,
    output logic [Y_W-1:0]   vga_y_o,
    output logic [COL_W-1:0] vga_col_o,
    output logic             vga_plot_o,
    output logic             oob_err_o
);

    arb_state_e       state_q;
    logic             last_b_q;
    logic [X_W-1:0]   vga_x_q;
    logic [Y_W-1:0]   vga_y_q;
    logic [COL_W-1:0] vga_col_q;
    logic             vga_plot_q, clear_busy_q, clear_done_q, oob_err_q;

    logic             ports_open, xfer, sel_in_frame;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [COL_W-1:0] sel_col;
    logic             sweep_start, sweep_en, sweep_last;
    logic [X_W-1:0]   sweep_x;
    logic [Y_W-1:0]   sweep_y;

    // A pending clear request blocks both ports on the edge it is taken.
    assign ports_open = (state_q == StIdle) && !clear_req_i;
    assign a_ready_o  = ports_open && a_valid_i && (!b_valid_i || last_b_q);
    assign b_ready_o  = ports_open && b_valid_i && (!a_valid_i || !last_b_q);

    assign xfer         = a_ready_o || b_ready_o;
    assign sel_x        = a_ready_o ? a_x_i   : b_x_i;
    assign sel_y        = a_ready_o ? a_y_i   : b_y_i;
    assign sel_col      = a_ready_o ? a_col_i : b_col_i;
    assign sel_in_frame = (32'(sel_x) < H_RES) && (32'(sel_y) < V_RES);

    assign sweep_start = (state_q == StIdle) && clear_req_i;
    assign sweep_en    = (state_q == StClear);

    vga_plot_arbiter_screen_sweep #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_sweep (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (sweep_start),
        .en_i    (sweep_en),
        .x_o     (sweep_x),
        .y_o     (sweep_y),
        .last_o  (sweep_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= AUTO_CLEAR ? StClear : StIdle;
            last_b_q     <= 1'b1;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_col_q    <= '0;
            vga_plot_q   <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            oob_err_q    <= 1'b0;
        end else begin
            vga_plot_q   <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (clear_req_i) begin
                        state_q <= StClear;
                    end else if (xfer) begin
                        last_b_q <= b_ready_o;
                        // Off-screen pixels are consumed but never reach the adapter.
                        if (sel_in_frame) begin
                            vga_x_q    <= sel_x;
                            vga_y_q    <= sel_y;
                            vga_col_q  <= sel_col;
                            vga_plot_q <= 1'b1;
                        end else begin
                            oob_err_q <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    vga_x_q      <= sweep_x;
                    vga_y_q      <= sweep_y;
                    vga_col_q    <= BG_COLOUR;
                    vga_plot_q   <= 1'b1;
                    clear_busy_q <= 1'b1;
                    if (sweep_last) begin
                        clear_done_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vga_x_o      = vga_x_q;
    assign vga_y_o      = vga_y_q;
    assign vga_col_o    = vga_col_q;
    assign vga_plot_o   = vga_plot_q;
    assign clear_busy_o = clear_busy_q;
    assign clear_done_o = clear_done_q;
    assign oob_err_o    = oob_err_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomised bench for vga_plot_arbiter against a pixel-index reference model;
// a second instance covers the no-auto-clear reset behaviour.
module tb_vga_plot_arbiter;

    localparam int H = 160;
    localparam int V = 120;
    localparam int N = H * V;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, clear_req, a_valid, b_valid;
    logic [7:0] a_x, b_x;
    logic [6:0] a_y, b_y;
    logic [2:0] a_col, b_col;
    logic       clear_busy, clear_done, a_ready, b_ready, vga_plot, oob_err;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_col;

    vga_plot_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .clear_req_i  (clear_req),
        .clear_busy_o (clear_busy),
        .clear_done_o (clear_done),
        .a_valid_i    (a_valid),
        .a_ready_o    (a_ready),
        .a_x_i        (a_x),
        .a_y_i        (a_y),
        .a_col_i      (a_col),
        .b_valid_i    (b_valid),
        .b_ready_o    (b_ready),
        .b_x_i        (b_x),
        .b_y_i        (b_y),
        .b_col_i      (b_col),
        .vga_x_o      (vga_x),
        .vga_y_o      (vga_y),
        .vga_col_o    (vga_col),
        .vga_plot_o   (vga_plot),
        .oob_err_o    (oob_err)
    );

    logic       nc_resetn, nc_clear, nc_a_valid, nc_b_valid;
    logic [7:0] nc_a_x, nc_b_x, nc_vga_x;
    logic [6:0] nc_a_y, nc_b_y, nc_vga_y;
    logic [2:0] nc_a_col, nc_b_col, nc_vga_col;
    logic       nc_busy, nc_done, nc_a_ready, nc_b_ready, nc_plot, nc_oob;

    vga_plot_arbiter #(.AUTO_CLEAR(1'b0)) u_nc (
        .clk          (clk),
        .resetn       (nc_resetn),
        .clear_req_i  (nc_clear),
        .clear_busy_o (nc_busy),
        .clear_done_o (nc_done),
        .a_valid_i    (nc_a_valid),
        .a_ready_o    (nc_a_ready),
        .a_x_i        (nc_a_x),
        .a_y_i        (nc_a_y),
        .a_col_i      (nc_a_col),
        .b_valid_i    (nc_b_valid),
        .b_ready_o    (nc_b_ready),
        .b_x_i        (nc_b_x),
        .b_y_i        (nc_b_y),
        .b_col_i      (nc_b_col),
        .vga_x_o      (nc_vga_x),
        .vga_y_o      (nc_vga_y),
        .vga_col_o    (nc_vga_col),
        .vga_plot_o   (nc_plot),
        .oob_err_o    (nc_oob)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: clear progress as a linear pixel index.
    bit         m_clear, m_last_b, m_oob;
    int         m_pix;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
    bit         e_plot, e_busy, e_done;
    bit         a_xfer, b_xfer, dut_a_rdy, dut_b_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] rand_x();
        if ($urandom_range(9, 0) == 0) return 8'($urandom_range(255, 160));
        return 8'($urandom_range(159, 0));
    endfunction

    function automatic logic [6:0] rand_y();
        if ($urandom_range(9, 0) == 0) return 7'($urandom_range(127, 120));
        return 7'($urandom_range(119, 0));
    endfunction

    task automatic check_outputs(input bit full);
        check("vga_plot", 32'(vga_plot), 32'(e_plot));
        check("clear_busy", 32'(clear_busy), 32'(e_busy));
        check("clear_done", 32'(clear_done), 32'(e_done));
        check("oob_err", 32'(oob_err), 32'(m_oob));
        if (e_plot || full) begin
            check("vga_x", 32'(vga_x), 32'(e_x));
            check("vga_y", 32'(vga_y), 32'(e_y));
            check("vga_col", 32'(vga_col), 32'(e_col));
        end
    endtask

    // Called just after an active edge with inputs already driven.
    task automatic cycle();
        bit e_a_rdy, e_b_rdy;
        int px, py;
        #1;
        e_a_rdy = !m_clear && !clear_req && a_valid && (!b_valid || m_last_b);
        e_b_rdy = !m_clear && !clear_req && b_valid && (!a_valid || !m_last_b);
        dut_a_rdy = a_ready;
        dut_b_rdy = b_ready;
        check("a_ready", 32'(a_ready), 32'(e_a_rdy));
        check("b_ready", 32'(b_ready), 32'(e_b_rdy));
        a_xfer = a_valid && e_a_rdy;
        b_xfer = b_valid && e_b_rdy;
        e_plot = 0;
        e_busy = 0;
        e_done = 0;
        if (m_clear) begin
            e_x    = 8'(m_pix % H);
            e_y    = 7'(m_pix / H);
            e_col  = 3'b000;
            e_plot = 1;
            e_busy = 1;
            if (m_pix == N - 1) begin
                e_done  = 1;
                m_clear = 0;
                m_pix   = 0;
            end else begin
                m_pix++;
            end
        end else if (clear_req) begin
            m_clear = 1;
            m_pix   = 0;
        end else if (a_xfer || b_xfer) begin
            px = a_xfer ? 32'(a_x) : 32'(b_x);
            py = a_xfer ? 32'(a_y) : 32'(b_y);
            m_last_b = b_xfer;
            if (px < H && py < V) begin
                e_x    = 8'(px);
                e_y    = 7'(py);
                e_col  = a_xfer ? a_col : b_col;
                e_plot = 1;
            end else begin
                m_oob = 1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(1'b0);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        clear_req = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        @(posedge clk);
        #1;
        m_clear  = 1;
        m_pix    = 0;
        m_last_b = 1;
        m_oob    = 0;
        e_x      = '0;
        e_y      = '0;
        e_col    = '0;
        e_plot   = 0;
        e_busy   = 0;
        e_done   = 0;
        a_xfer   = 0;
        b_xfer   = 0;
        check_outputs(1'b1);
        resetn = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (a_xfer) a_valid = 1'b0;
            if (b_xfer) b_valid = 1'b0;
            if (!a_valid && !b_valid) break;
            cycle();
        end
    endtask

    task automatic run_nc_test();
        int k;
        nc_resetn = 1'b0;
        @(posedge clk);
        #1;
        check("nc_rst_plot", 32'(nc_plot), 0);
        nc_resetn = 1'b1;
        @(posedge clk);
        #1;
        check("nc_no_auto_plot", 32'(nc_plot), 0);
        check("nc_no_auto_busy", 32'(nc_busy), 0);
        nc_clear = 1'b1;
        @(posedge clk);
        #1;
        nc_clear = 1'b0;
        k = 0;
        while (!(nc_plot && nc_vga_x == 8'd40 && nc_vga_y == 7'd10) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("nc_cycles_to_40_10", 32'(k), 32'(40 + 10 * H + 1));
        check("nc_sweep_a_ready", 32'(nc_a_ready), 0);
        nc_resetn  = 1'b0;
        nc_a_valid = 1'b1;
        nc_a_x     = 8'd7;
        nc_a_y     = 7'd8;
        nc_a_col   = 3'b010;
        @(posedge clk);
        #1;
        check("nc_rst_x", 32'(nc_vga_x), 0);
        check("nc_rst_y", 32'(nc_vga_y), 0);
        check("nc_rst_col", 32'(nc_vga_col), 0);
        check("nc_rst_plot2", 32'(nc_plot), 0);
        check("nc_rst_busy", 32'(nc_busy), 0);
        check("nc_rst_done", 32'(nc_done), 0);
        check("nc_rst_oob", 32'(nc_oob), 0);
        check("nc_idle_a_ready", 32'(nc_a_ready), 1);
        nc_resetn = 1'b1;
        @(posedge clk);
        #1;
        nc_a_valid = 1'b0;
        check("nc_xfer_plot", 32'(nc_plot), 1);
        check("nc_xfer_x", 32'(nc_vga_x), 7);
        check("nc_xfer_y", 32'(nc_vga_y), 8);
        check("nc_xfer_col", 32'(nc_vga_col), 2);
        @(posedge clk);
        #1;
        check("nc_after_plot", 32'(nc_plot), 0);
    endtask

    initial begin
        int k, pulses, stalls;
        resetn = 1'b0; clear_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_x = '0; a_y = '0; a_col = '0; b_x = '0; b_y = '0; b_col = '0;
        nc_resetn = 1'b0; nc_clear = 1'b0; nc_a_valid = 1'b0; nc_b_valid = 1'b0;
        nc_a_x = '0; nc_a_y = '0; nc_a_col = '0; nc_b_x = '0; nc_b_y = '0; nc_b_col = '0;

        run_nc_test();

        // Auto clear after reset, with both requesters stalled throughout.
        do_reset();
        a_valid = 1'b1; a_x = 8'd10; a_y = 7'd20; a_col = 3'd1;
        b_valid = 1'b1; b_x = 8'd30; b_y = 7'd40; b_col = 3'd2;
        pulses = 0;
        k = 0;
        while (m_clear && k < N + 50) begin
            cycle();
            if (vga_plot) pulses++;
            clear_req = m_clear ? ($urandom_range(7, 0) == 0) : 1'b0;
            k++;
        end
        clear_req = 1'b0;
        check("auto_clear_pulses", 32'(pulses), 32'(N));
        cycle();
        check("post_clear_grant_a", 32'(dut_a_rdy), 1);
        if (a_xfer) a_valid = 1'b0;
        cycle();
        check("second_grant_b", 32'(dut_b_rdy), 1);
        drain();

        a_valid = 1'b1; a_x = 8'd85; a_y = 7'd55; a_col = 3'b100;
        cycle();
        check("a_only_ready", 32'(dut_a_rdy), 1);
        a_valid = 1'b0;
        cycle();

        b_valid = 1'b1; b_x = 8'd3; b_y = 7'd4; b_col = 3'd5;
        cycle();
        b_valid = 1'b0;

        for (int t = 0; t < 4; t++) begin
            if (t == 0 || a_xfer) begin
                a_x = 8'($urandom_range(159, 0)); a_y = 7'($urandom_range(119, 0));
                a_col = 3'($urandom_range(7, 0));
            end
            if (t == 0 || b_xfer) begin
                b_x = 8'($urandom_range(159, 0)); b_y = 7'($urandom_range(119, 0));
                b_col = 3'($urandom_range(7, 0));
            end
            a_valid = 1'b1;
            b_valid = 1'b1;
            cycle();
            check("tie_grant_a", 32'(dut_a_rdy), 32'((t % 2) == 0));
            check("tie_grant_b", 32'(dut_b_rdy), 32'((t % 2) == 1));
        end
        drain();

        b_valid = 1'b1; b_x = 8'd160; b_y = 7'd5; b_col = 3'd7;
        cycle();
        check("oob_b_ready", 32'(dut_b_rdy), 1);
        b_valid = 1'b0;
        cycle();
        cycle();

        for (int t = 0; t < 400; t++) begin
            if (!a_valid || a_xfer) begin
                a_valid = ($urandom_range(2, 0) != 0);
                a_x = rand_x(); a_y = rand_y(); a_col = 3'($urandom_range(7, 0));
            end
            if (!b_valid || b_xfer) begin
                b_valid = ($urandom_range(2, 0) != 0);
                b_x = rand_x(); b_y = rand_y(); b_col = 3'($urandom_range(7, 0));
            end
            cycle();
        end
        drain();

        // Clear request beats a simultaneous port A request.
        clear_req = 1'b1;
        a_valid = 1'b1; a_x = 8'd12; a_y = 7'd34; a_col = 3'd6;
        stalls = 0;
        k = 0;
        do begin
            cycle();
            if (!dut_a_rdy) stalls++;
            clear_req = m_clear ? ($urandom_range(7, 0) == 0) : 1'b0;
            k++;
        end while (!a_xfer && k < N + 50);
        clear_req = 1'b0;
        check("clear_req_stall_cycles", 32'(stalls), 32'(N + 1));
        a_valid = 1'b0;
        cycle();

        // Reset mid-sweep; the auto clear restarts from the origin.
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        k = 0;
        while (!(e_plot && e_x == 8'd40 && e_y == 7'd10) && k < N + 50) begin
            cycle();
            k++;
        end
        check("reached_40_10", 32'(k), 32'(40 + 10 * H + 1));
        do_reset();
        for (int t = 0; t < 3; t++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
